// File: rtl/subleq_mem_if.sv
// Single-port RAM bus between the SUBLEQ sequencer (master) and the program RAM (slave).
interface subleq_mem_if #(
   parameter int P_ADDR = 8,
   parameter int P_DATA = 8
);
   logic              mem_rw;
   logic [P_ADDR-1:0] mem_addr;
   logic [P_DATA-1:0] mem_wdata;
   logic [P_DATA-1:0] mem_rdata;

   modport master (output mem_rw, output mem_addr, output mem_wdata, input mem_rdata);
   modport slave  (input mem_rw, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/subleq_sequencer.sv
// SUBLEQ execution engine: fetches (a, b, c), writes mem[b]-mem[a] back to b and
// branches to c on a non-positive result; c all-ones on a taken branch halts.
//
// state  | meaning
// IDLE   | waiting for start after reset
// FA     | address pc, RAM returns word a next cycle
// FB     | address pc+1, latch a
// FC     | address pc+2, latch b
// RA     | address a, latch c
// RB     | address b, latch mem[a] into va
// WR     | write mem[b]-va to b, update pc and icount
// HALTED | program ended, waiting for start
module subleq_sequencer #(
   parameter int P_ADDR  = 8,
   parameter int P_DATA  = 8,
   parameter int P_ENTRY = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   subleq_mem_if.master      bus,
   output logic              busy,
   output logic              halted,
   output logic [P_ADDR-1:0] pc,
   output logic [15:0]       icount
);

   localparam logic [P_ADDR-1:0] ENTRY = P_ADDR'(P_ENTRY);

   typedef enum logic [2:0] {
      S_IDLE, S_FA, S_FB, S_FC, S_RA, S_RB, S_WR, S_HALTED
   } state_t;

   state_t            state, state_nxt;
   logic [P_ADDR-1:0] a, b, c;
   logic [P_DATA-1:0] va;
   logic [P_DATA-1:0] r;
   logic              r_le0;

   // mem_rdata during WR is mem[b], requested while in RB
   assign r      = bus.mem_rdata - va;
   assign r_le0  = r[P_DATA-1] | (r == '0);
   assign busy   = (state != S_IDLE) && (state != S_HALTED);
   assign halted = (state == S_HALTED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.mem_rw    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (state)
         S_IDLE, S_HALTED: if (start) state_nxt = S_FA;
         S_FA: begin
            bus.mem_addr = pc;
            state_nxt    = S_FB;
         end
         S_FB: begin
            bus.mem_addr = pc + P_ADDR'(1);
            state_nxt    = S_FC;
         end
         S_FC: begin
            bus.mem_addr = pc + P_ADDR'(2);
            state_nxt    = S_RA;
         end
         S_RA: begin
            bus.mem_addr = a;
            state_nxt    = S_RB;
         end
         S_RB: begin
            bus.mem_addr = b;
            state_nxt    = S_WR;
         end
         S_WR: begin
            bus.mem_rw    = 1'b1;
            bus.mem_addr  = b;
            bus.mem_wdata = r;
            state_nxt     = (r_le0 && (&c)) ? S_HALTED : S_FA;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc     <= ENTRY;
         icount <= '0;
         a      <= '0;
         b      <= '0;
         c      <= '0;
         va     <= '0;
      end else begin
         case (state)
            S_IDLE, S_HALTED: begin
               if (start) begin
                  pc     <= ENTRY;
                  icount <= '0;
               end
            end
            S_FB: a  <= bus.mem_rdata[P_ADDR-1:0];
            S_FC: b  <= bus.mem_rdata[P_ADDR-1:0];
            S_RA: c  <= bus.mem_rdata[P_ADDR-1:0];
            S_RB: va <= bus.mem_rdata;
            S_WR: begin
               if (icount != 16'hFFFF) icount <= icount + 16'd1;
               pc <= r_le0 ? c : pc + P_ADDR'(3);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_subleq_sequencer.sv
// Bench for subleq_sequencer: directed program scenarios plus random programs
// checked instruction by instruction against an interpreter-level model.
module tb_subleq_sequencer;

   logic clk = 1'b0;
   logic rst;
   logic start0, start1;
   logic busy0, halted0, busy1, halted1;
   logic [7:0]  pc0, pc1;
   logic [15:0] icount0, icount1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   subleq_mem_if #(.P_ADDR(8), .P_DATA(8)) bus0 ();
   subleq_mem_if #(.P_ADDR(8), .P_DATA(8)) bus1 ();

   subleq_sequencer #(.P_ADDR(8), .P_DATA(8), .P_ENTRY(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .bus(bus0.master),
      .busy(busy0), .halted(halted0), .pc(pc0), .icount(icount0)
   );

   subleq_sequencer #(.P_ADDR(8), .P_DATA(8), .P_ENTRY(254)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .bus(bus1.master),
      .busy(busy1), .halted(halted1), .pc(pc1), .icount(icount1)
   );

   // RAM models with a backdoor load port used only while the DUTs are idle
   logic [7:0] ram0 [256];
   logic [7:0] ram1 [256];
   logic [7:0] dout0, dout1;
   int         wr0 = 0;
   logic       pk_en = 1'b0, pk_sel = 1'b0;
   logic [7:0] pk_addr = '0, pk_data = '0;

   assign bus0.mem_rdata = dout0;
   assign bus1.mem_rdata = dout1;

   always @(posedge clk) begin
      if (pk_en) begin
         if (pk_sel) ram1[pk_addr] <= pk_data;
         else        ram0[pk_addr] <= pk_data;
      end
      if (bus0.mem_rw) begin
         ram0[bus0.mem_addr] <= bus0.mem_wdata;
         wr0 <= wr0 + 1;
      end else begin
         dout0 <= ram0[bus0.mem_addr];
      end
      if (bus1.mem_rw) ram1[bus1.mem_addr] <= bus1.mem_wdata;
      else             dout1 <= ram1[bus1.mem_addr];
   end

   // Reference interpreter state
   logic [7:0]  mdl [256];
   logic [7:0]  mpc, last_b;
   logic [15:0] micount;
   logic        mhalt;
   int          wr_snap;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic sel, input logic [7:0] addr, input logic [7:0] data);
      pk_sel = sel; pk_addr = addr; pk_data = data; pk_en = 1'b1;
      if (!sel) mdl[addr] = data;
      tick(1);
      pk_en = 1'b0;
   endtask

   task automatic clear(input logic sel);
      for (int i = 0; i < 256; i++) poke(sel, 8'(i), 8'h00);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   task automatic pulse0();
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
   endtask

   task automatic model_exec();
      logic [7:0] a, b, c, r;
      a = mdl[mpc];
      b = mdl[mpc + 8'd1];
      c = mdl[mpc + 8'd2];
      r = mdl[b] - mdl[a];
      mdl[b] = r;
      last_b = b;
      if (micount != 16'hFFFF) micount = micount + 16'd1;
      if ($signed(r) <= 0) begin
         mpc = c;
         if (c == 8'hFF) mhalt = 1'b1;
      end else begin
         mpc = mpc + 8'd3;
      end
   endtask

   initial begin
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
      tick(2);
      check("rst_busy", busy0, 0);
      check("rst_halted", halted0, 0);
      check("rst_rw", bus0.mem_rw, 0);
      check("rst_addr", bus0.mem_addr, 0);
      check("rst_wdata", bus0.mem_wdata, 0);
      check("rst_pc", pc0, 0);
      check("rst_icount", icount0, 0);
      check("rst_pc_entry254", pc1, 254);
      rst = 1'b0;
      tick(1);

      // basic not-taken subtract, then a halting instruction
      clear(0);
      poke(0, 0, 10); poke(0, 1, 11); poke(0, 2, 3);
      poke(0, 3, 10); poke(0, 4, 10); poke(0, 5, 255);
      poke(0, 10, 3); poke(0, 11, 5);
      pulse0();
      tick(6);
      check("basic_mem11", ram0[11], 2);
      check("basic_pc", pc0, 3);
      check("basic_icount", icount0, 1);
      check("basic_busy", busy0, 1);
      tick(6);
      check("halt_mem10", ram0[10], 0);
      check("halt_pc", pc0, 255);
      check("halt_halted", halted0, 1);
      check("halt_busy", busy0, 0);
      check("halt_icount", icount0, 2);
      check("halt_addr", bus0.mem_addr, 0);
      wr_snap = wr0;
      tick(10);
      check("halt_no_writes", wr0, wr_snap);

      // restart from HALTED: mem[11]=2, mem[10]=0 -> 2-0 not taken, then 0-0 halts
      pulse0();
      check("restart_pc", pc0, 0);
      check("restart_icount", icount0, 0);
      check("restart_busy", busy0, 1);
      tick(6);
      check("restart_mem11", ram0[11], 2);
      check("restart_pc3", pc0, 3);
      tick(6);
      check("restart_halted", halted0, 1);
      check("restart_icount2", icount0, 2);

      // taken jump to 9
      do_reset();
      clear(0);
      poke(0, 0, 20); poke(0, 1, 21); poke(0, 2, 9);
      poke(0, 20, 7); poke(0, 21, 7);
      pulse0();
      tick(6);
      check("jump_mem21", ram0[21], 0);
      check("jump_pc", pc0, 9);
      check("jump_halted", halted0, 0);

      // signed wrap: 0x80-0x01=0x7F positive, then 0x00-0x01=0xFF taken to 255
      do_reset();
      clear(0);
      poke(0, 0, 30); poke(0, 1, 31); poke(0, 2, 50);
      poke(0, 3, 32); poke(0, 4, 33); poke(0, 5, 255);
      poke(0, 30, 8'h01); poke(0, 31, 8'h80);
      poke(0, 32, 8'h01); poke(0, 33, 8'h00);
      pulse0();
      tick(6);
      check("wrap_mem31", ram0[31], 8'h7F);
      check("wrap_pc", pc0, 3);
      tick(6);
      check("neg_mem33", ram0[33], 8'hFF);
      check("neg_pc", pc0, 255);
      check("neg_halted", halted0, 1);

      // pc wrap on the P_ENTRY=254 instance
      clear(1);
      poke(1, 254, 40); poke(1, 255, 41); poke(1, 0, 60);
      poke(1, 40, 1); poke(1, 41, 5);
      start1 = 1'b1;
      tick(1);
      start1 = 1'b0;
      check("pcwrap_fa_addr", bus1.mem_addr, 254);
      tick(1);
      check("pcwrap_fb_addr", bus1.mem_addr, 255);
      tick(1);
      check("pcwrap_fc_addr", bus1.mem_addr, 0);
      tick(1);
      check("pcwrap_ra_addr", bus1.mem_addr, 40);
      tick(1);
      check("pcwrap_rb_addr", bus1.mem_addr, 41);
      tick(1);
      check("pcwrap_wr_rw", bus1.mem_rw, 1);
      check("pcwrap_wr_wdata", bus1.mem_wdata, 4);
      tick(1);
      check("pcwrap_pc", pc1, 1);
      check("pcwrap_mem41", ram1[41], 4);

      // reset asserted while in WR
      do_reset();
      clear(0);
      poke(0, 0, 10); poke(0, 1, 11); poke(0, 2, 3);
      poke(0, 10, 1); poke(0, 11, 9);
      pulse0();
      tick(5);
      check("rstwr_rw_before", bus0.mem_rw, 1);
      wr_snap = wr0;
      rst = 1'b1;
      #1;
      check("rstwr_rw", bus0.mem_rw, 0);
      check("rstwr_addr", bus0.mem_addr, 0);
      check("rstwr_wdata", bus0.mem_wdata, 0);
      check("rstwr_busy", busy0, 0);
      check("rstwr_pc", pc0, 0);
      tick(1);
      rst = 1'b0;
      check("rstwr_no_write", wr0, wr_snap);
      check("rstwr_mem11", ram0[11], 9);

      // start during FB is ignored
      pulse0();
      tick(1);
      pulse0();
      tick(4);
      check("startfb_pc", pc0, 3);
      check("startfb_icount", icount0, 1);
      check("startfb_mem11", ram0[11], 8);

      // random programs against the interpreter model
      for (int round = 0; round < 4; round++) begin
         do_reset();
         for (int i = 0; i < 256; i++) poke(0, 8'(i), 8'($urandom_range(0, 255)));
         mpc = 8'd0; micount = 16'd0; mhalt = 1'b0;
         pulse0();
         for (int k = 0; k < 12 && !mhalt; k++) begin
            tick(6);
            model_exec();
            check("rand_pc", pc0, mpc);
            check("rand_icount", icount0, micount);
            check("rand_halted", halted0, mhalt);
            check("rand_memb", ram0[last_b], mdl[last_b]);
         end
      end
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/subleq_sequencer.md
Name: subleq_sequencer

Overview:
- Control FSM that runs a SUBLEQ program held in the single-port RAM (P_ADDR/P_DATA/P_MEM parameterised, synchronous, rw=1 write / rw=0 read, dout registered with 1-cycle read latency).
- Fetches operand triple (a, b, c) at pc, pc+1, pc+2, executes mem[b] <= mem[b] - mem[a], and branches to c if the result is <= 0 (signed).
- Owns the RAM port exclusively while busy. Sits between the RAM and the top level.

Parameters:
- P_ADDR, 8, address width; also the width of pc and of the a/b/c address fields.
- P_DATA, 8, data width; must be >= P_ADDR.
- P_ENTRY, 0, pc loaded on reset and on an accepted start.

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin execution from P_ENTRY; sampled only in IDLE or HALTED.
- mem_rw  out  1  RAM rw.
- mem_addr  out  P_ADDR  RAM addr.
- mem_wdata  out  P_DATA  RAM din.
- mem_rdata  in  P_DATA  RAM dout.
- busy  out  1  high in every state except IDLE and HALTED.
- halted  out  1  high in HALTED.
- pc  out  P_ADDR  current instruction address.
- icount  out  16  completed instructions since the last start, saturating at 0xFFFF.

Behaviour:
- Reset (async):
  - state=IDLE, pc=P_ENTRY, icount=0, internal a/b/c/va latches=0.
  - mem_rw, mem_addr, mem_wdata, busy and halted are all 0 immediately.
- RAM outputs are combinational decodes of state and latches. mem_rw=1 only in WR. mem_addr=0 and mem_wdata=0 in IDLE and HALTED.
- States and transitions (6 cycles per instruction):
  - IDLE: if start, then pc<=P_ENTRY, icount<=0, go FA.
  - FA: addr=pc. Go FB.
  - FB: addr=pc+1. Latch a<=mem_rdata[P_ADDR-1:0]. Go FC.
  - FC: addr=pc+2. Latch b<=mem_rdata[P_ADDR-1:0]. Go RA.
  - RA: addr=a. Latch c<=mem_rdata[P_ADDR-1:0]. Go RB.
  - RB: addr=b. Latch va<=mem_rdata. Go WR.
  - WR: addr=b, rw=1, wdata=r where r=mem_rdata-va. icount++ (saturating).
    - If r is signed <= 0 (MSB set or r==0) and c is all-ones: pc<=c, go HALTED.
    - Else if r <= 0: pc<=c, go FA.
    - Else: pc<=pc+3, go FA.
  - HALTED: if start, then pc<=P_ENTRY, icount<=0, go FA.
- Arithmetic:
  - The subtraction is P_DATA-bit two's complement and wraps; overflow is not detected.
  - pc+1, pc+2 and pc+3 are modulo 2^P_ADDR, so an instruction may straddle the top of memory.
  - Address fields use the low P_ADDR bits of each word; upper bits are ignored.
- Self-modifying code is legal. The WR write lands at the WR edge, so the next FA read returns the new value. a==b and b==pc+k also behave per the RAM's write-then-read ordering.
- The halting instruction still performs its write.
- start is ignored while busy; no effect on state or pc.
- rst asserted during WR: mem_rw drops combinationally. If rst is high at the edge, no write occurs.

Test Plan:
- Basic subtract, not taken: mem[0..2]=10,11,3; mem[10]=3; mem[11]=5. Pulse start. Required: exactly 6 cycles later mem[11]=2, pc=3, icount=1, busy=1.
- Taken halt: continue the first program with mem[3..5]=10,10,255. Required: mem[10]=0, pc=255, halted=1, busy=0, icount=2, no further RAM writes; a second start re-runs from pc=0.
- Taken non-halt jump: mem[0..2]=20,21,9; mem[20]=7; mem[21]=7. Required: mem[21]=0, pc=9.
- Signed wrap: mem[b]=0x80, mem[a]=0x01. Required: result 0x7F treated as positive, branch not taken, pc+=3. Also check mem[b]=0x00, mem[a]=0x01: result 0xFF, taken.
- pc wrap with P_ENTRY=254: instruction words at 254, 255, 0. Required: operands fetched from those addresses in order; a not-taken result gives pc=1.
- Reset and start robustness:
  - rst asserted in WR: no write, all outputs 0, pc=P_ENTRY.
  - start pulsed during FB: ignored; the instruction completes in the normal 6 cycles.
